// File: rtl/cr_huf_comp_st_long_sched.sv
// cr_huf_comp_st_long_sched
//   Steers whole frames of long-symbol histogram beats to one of two table
//   builders, alternating round-robin between idle and enabled builders. It
//   stalls the beat stream when no builder can take a new frame. It also keeps
//   a 2-entry completion-order queue, so symbol assembly reads builders in
//   frame order.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_val, in_eob, in_seq_id   histogram beat stream (seq_id taken on first beat)
//   in_stall                    beat not accepted this cycle (combinational)
//   bld_val[1:0]                one-hot beat strobe to builder 0/1 (combinational)
//   bld_not_ready[1:0]          per-builder backpressure
//   bld_read_done[1:0]          per-builder "table consumed" pulse
//   sw_enable[1:0]              builder enable mask
//   bld0_seq_id, bld1_seq_id    seq_id of the frame owned by each builder
//   sa_sel, sa_sel_vld          head of the completion-order queue
//   dispatch_cnt0/1             saturating per-builder frame counters
//   order_err                   one-cycle pulse on out-of-order/spurious done
module cr_huf_comp_st_long_sched #(
    parameter int SEQ_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    input  logic             in_eob,
    input  logic [SEQ_W-1:0] in_seq_id,
    output logic             in_stall,
    output logic [1:0]       bld_val,
    input  logic [1:0]       bld_not_ready,
    input  logic [1:0]       bld_read_done,
    input  logic [1:0]       sw_enable,
    output logic [SEQ_W-1:0] bld0_seq_id,
    output logic [SEQ_W-1:0] bld1_seq_id,
    output logic             sa_sel,
    output logic             sa_sel_vld,
    output logic [CNT_W-1:0] dispatch_cnt0,
    output logic [CNT_W-1:0] dispatch_cnt1,
    output logic             order_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BUSY} bld_state_t;

    bld_state_t st     [2];
    bld_state_t st_nxt [2];

    logic       frame_open;
    logic       sel;
    logic       rr_ptr;
    logic       q0, q1;
    logic [1:0] qcnt;

    logic [1:0] elig;
    logic       any_elig;
    logic       chosen;
    logic       route;
    logic       accept;
    logic       start;
    logic [1:0] done_ok;
    logic       pop;

    // Beat path: fully combinational, zero latency
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = (st[i] == ST_IDLE) && sw_enable[i];
        end
        any_elig = |elig;
        chosen   = elig[rr_ptr] ? rr_ptr : ~rr_ptr;
        route    = frame_open ? sel : chosen;
        in_stall = frame_open ? bld_not_ready[sel]
                              : (!any_elig || bld_not_ready[chosen]);
        // Gating with rst keeps the strobes quiet while reset is held.
        accept   = in_val && !in_stall && !rst;
        start    = accept && !frame_open;
        bld_val  = 2'b00;
        if (accept) bld_val[route] = 1'b1;
    end

    // A done is honoured only from the BUSY builder at the head of the queue
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            done_ok[i] = bld_read_done[i] && sa_sel_vld && (sa_sel == 1'(i))
                         && (st[i] == ST_BUSY);
        end
        pop = |done_ok;
    end

    // Per-builder FSM next state
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                ST_IDLE: if (start && (route == 1'(i)))
                             st_nxt[i] = in_eob ? ST_BUSY : ST_LOAD;
                ST_LOAD: if (accept && (sel == 1'(i)) && in_eob)
                             st_nxt[i] = ST_BUSY;
                ST_BUSY: if (done_ok[i])
                             st_nxt[i] = ST_IDLE;
                default: st_nxt[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st[0] <= ST_IDLE;
            st[1] <= ST_IDLE;
        end else begin
            st[0] <= st_nxt[0];
            st[1] <= st_nxt[1];
        end
    end

    // Frame tracking, round-robin pointer, seq_id capture, counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_open    <= 1'b0;
            sel           <= 1'b0;
            rr_ptr        <= 1'b0;
            bld0_seq_id   <= '0;
            bld1_seq_id   <= '0;
            dispatch_cnt0 <= '0;
            dispatch_cnt1 <= '0;
            order_err     <= 1'b0;
        end else begin
            order_err <= |(bld_read_done & ~done_ok);
            if (start) begin
                sel        <= chosen;
                rr_ptr     <= ~chosen;
                frame_open <= !in_eob;
                if (chosen == 1'b0) begin
                    bld0_seq_id <= in_seq_id;
                    if (dispatch_cnt0 != '1) dispatch_cnt0 <= dispatch_cnt0 + 1'b1;
                end else begin
                    bld1_seq_id <= in_seq_id;
                    if (dispatch_cnt1 != '1) dispatch_cnt1 <= dispatch_cnt1 + 1'b1;
                end
            end else if (accept && in_eob) begin
                frame_open <= 1'b0;
            end
        end
    end

    // Completion-order queue; q0 is the head and drives sa_sel directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0   <= 1'b0;
            q1   <= 1'b0;
            qcnt <= 2'd0;
        end else begin
            if (start && pop) begin
                if (qcnt == 2'd2) begin
                    q0 <= q1;
                    q1 <= chosen;
                end else begin
                    q0 <= chosen;
                end
            end else if (start) begin
                if (qcnt == 2'd0) q0 <= chosen;
                else              q1 <= chosen;
                qcnt <= qcnt + 2'd1;
            end else if (pop) begin
                q0   <= q1;
                qcnt <= qcnt - 2'd1;
            end
        end
    end

    assign sa_sel     = q0;
    assign sa_sel_vld = (qcnt != 2'd0);

endmodule

// File: tb/tb_cr_huf_comp_st_long_sched.sv
// Directed testbench for cr_huf_comp_st_long_sched.
// Inputs change 1 time unit after the rising edge; outputs are checked
// before the next rising edge.
module tb_cr_huf_comp_st_long_sched;

    localparam int SEQ_W = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_val;
    logic             in_eob;
    logic [SEQ_W-1:0] in_seq_id;
    logic             in_stall;
    logic [1:0]       bld_val;
    logic [1:0]       bld_not_ready;
    logic [1:0]       bld_read_done;
    logic [1:0]       sw_enable;
    logic [SEQ_W-1:0] bld0_seq_id;
    logic [SEQ_W-1:0] bld1_seq_id;
    logic             sa_sel;
    logic             sa_sel_vld;
    logic [CNT_W-1:0] dispatch_cnt0;
    logic [CNT_W-1:0] dispatch_cnt1;
    logic             order_err;

    int n_checks = 0;
    int n_fail   = 0;

    cr_huf_comp_st_long_sched #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_val        (in_val),
        .in_eob        (in_eob),
        .in_seq_id     (in_seq_id),
        .in_stall      (in_stall),
        .bld_val       (bld_val),
        .bld_not_ready (bld_not_ready),
        .bld_read_done (bld_read_done),
        .sw_enable     (sw_enable),
        .bld0_seq_id   (bld0_seq_id),
        .bld1_seq_id   (bld1_seq_id),
        .sa_sel        (sa_sel),
        .sa_sel_vld    (sa_sel_vld),
        .dispatch_cnt0 (dispatch_cnt0),
        .dispatch_cnt1 (dispatch_cnt1),
        .order_err     (order_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_val = 1'b0; in_eob = 1'b0; in_seq_id = '0;
        bld_not_ready = 2'b00; bld_read_done = 2'b00; sw_enable = 2'b00;
        tick();
        #1;
        // Reset state
        chk("rst_stall_en0", 32'(in_stall), 1);
        sw_enable = 2'b11;
        #1;
        chk("rst_stall_en3", 32'(in_stall), 0);
        chk("rst_bld_val", 32'(bld_val), 0);
        chk("rst_sa_sel", 32'(sa_sel), 0);
        chk("rst_sa_vld", 32'(sa_sel_vld), 0);
        chk("rst_seq0", 32'(bld0_seq_id), 0);
        chk("rst_seq1", 32'(bld1_seq_id), 0);
        chk("rst_cnt0", 32'(dispatch_cnt0), 0);
        chk("rst_cnt1", 32'(dispatch_cnt1), 0);
        chk("rst_err", 32'(order_err), 0);
        tick();
        rst = 1'b0;
        #1;

        // Back-to-back single-beat frames 3 and 4, third one stalls
        in_val = 1'b1; in_eob = 1'b1; in_seq_id = 5'd3;
        #1;
        chk("f3_bld_val", 32'(bld_val), 32'h1);
        chk("f3_stall", 32'(in_stall), 0);
        tick();
        in_seq_id = 5'd4;
        #1;
        chk("f4_bld_val", 32'(bld_val), 32'h2);
        chk("f4_stall", 32'(in_stall), 0);
        tick();
        in_seq_id = 5'd5;
        #1;
        chk("f5_stall", 32'(in_stall), 1);
        chk("f5_bld_val", 32'(bld_val), 0);
        chk("f34_seq0", 32'(bld0_seq_id), 3);
        chk("f34_seq1", 32'(bld1_seq_id), 4);
        chk("f34_sa_sel", 32'(sa_sel), 0);
        chk("f34_sa_vld", 32'(sa_sel_vld), 1);
        chk("f34_cnt0", 32'(dispatch_cnt0), 1);
        chk("f34_cnt1", 32'(dispatch_cnt1), 1);
        in_val = 1'b0;

        // Out-of-order done: builder 1 is not the head
        bld_read_done = 2'b10;
        tick();
        bld_read_done = 2'b00;
        #1;
        chk("ooo_err_pulse", 32'(order_err), 1);
        chk("ooo_sa_sel", 32'(sa_sel), 0);
        chk("ooo_sa_vld", 32'(sa_sel_vld), 1);
        tick();
        chk("ooo_err_clear", 32'(order_err), 0);

        // done[0] in cycle N with frame 6 waiting: stalls in N, accepted in N+1
        in_val = 1'b1; in_eob = 1'b1; in_seq_id = 5'd6;
        bld_read_done = 2'b01;
        #1;
        chk("n_stall", 32'(in_stall), 1);
        chk("n_bld_val", 32'(bld_val), 0);
        tick();
        bld_read_done = 2'b00;
        #1;
        chk("n1_stall", 32'(in_stall), 0);
        chk("n1_bld_val", 32'(bld_val), 32'h1);
        chk("n1_sa_sel", 32'(sa_sel), 1);
        chk("n1_err", 32'(order_err), 0);
        tick();
        in_val = 1'b0;
        #1;
        chk("f6_seq0", 32'(bld0_seq_id), 6);
        chk("f6_sa_sel", 32'(sa_sel), 1);
        chk("f6_cnt0", 32'(dispatch_cnt0), 2);
        bld_read_done = 2'b10;
        tick();
        bld_read_done = 2'b00;
        #1;
        chk("pop1_sa_sel", 32'(sa_sel), 0);
        chk("pop1_sa_vld", 32'(sa_sel_vld), 1);
        bld_read_done = 2'b01;
        tick();
        bld_read_done = 2'b00;
        #1;
        chk("pop0_sa_vld", 32'(sa_sel_vld), 0);
        chk("pop0_err", 32'(order_err), 0);

        // 4-beat frame on builder 0 with 2 not-ready cycles
        do_reset();
        in_val = 1'b1; in_eob = 1'b0; in_seq_id = 5'd7;
        #1;
        chk("m_b1_bld_val", 32'(bld_val), 32'h1);
        tick();
        chk("m_b2_bld_val", 32'(bld_val), 32'h1);
        chk("m_b2_stall", 32'(in_stall), 0);
        tick();
        bld_not_ready = 2'b01;
        #1;
        chk("m_nr1_stall", 32'(in_stall), 1);
        chk("m_nr1_bld_val", 32'(bld_val), 0);
        tick();
        chk("m_nr2_stall", 32'(in_stall), 1);
        tick();
        bld_not_ready = 2'b00;
        #1;
        chk("m_b3_stall", 32'(in_stall), 0);
        chk("m_b3_bld_val", 32'(bld_val), 32'h1);
        tick();
        in_eob = 1'b1;
        #1;
        chk("m_b4_bld_val", 32'(bld_val), 32'h1);
        tick();
        in_val = 1'b0; in_eob = 1'b0;
        sw_enable = 2'b01;
        #1;
        chk("m_cnt0", 32'(dispatch_cnt0), 1);
        chk("m_seq0", 32'(bld0_seq_id), 7);
        chk("m_sa_vld", 32'(sa_sel_vld), 1);
        chk("m_busy_stall", 32'(in_stall), 1);

        // Only builder 1 enabled: three frames, each released by done
        do_reset();
        sw_enable = 2'b10;
        for (int k = 0; k < 3; k++) begin
            in_val = 1'b1; in_eob = 1'b1; in_seq_id = 5'(10 + k);
            #1;
            chk("en1_bld_val", 32'(bld_val), 32'h2);
            tick();
            in_val = 1'b0;
            bld_read_done = 2'b10;
            tick();
            bld_read_done = 2'b00;
            #1;
        end
        chk("en1_cnt0", 32'(dispatch_cnt0), 0);
        chk("en1_cnt1", 32'(dispatch_cnt1), 3);
        chk("en1_seq1", 32'(bld1_seq_id), 12);
        chk("en1_sa_vld", 32'(sa_sel_vld), 0);
        chk("en1_err", 32'(order_err), 0);

        // Async reset during beat 2 of a 5-beat frame
        sw_enable = 2'b11;
        do_reset();
        in_val = 1'b1; in_eob = 1'b0; in_seq_id = 5'd20;
        #1;
        chk("r_b1_bld_val", 32'(bld_val), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("r_rst_bld_val", 32'(bld_val), 0);
        chk("r_rst_stall", 32'(in_stall), 0);
        chk("r_rst_seq0", 32'(bld0_seq_id), 0);
        chk("r_rst_cnt0", 32'(dispatch_cnt0), 0);
        chk("r_rst_sa_vld", 32'(sa_sel_vld), 0);
        tick();
        rst = 1'b0;
        in_seq_id = 5'd21;
        #1;
        chk("r_new_bld_val", 32'(bld_val), 32'h1);
        chk("r_new_stall", 32'(in_stall), 0);
        tick();
        in_val = 1'b0;
        #1;
        chk("r_new_seq0", 32'(bld0_seq_id), 21);
        chk("r_new_cnt0", 32'(dispatch_cnt0), 1);
        chk("r_new_sa_vld", 32'(sa_sel_vld), 1);
        chk("r_new_sa_sel", 32'(sa_sel), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cr_huf_comp_st_long_sched.md
# cr_huf_comp_st_long_sched

Frame scheduler for the two long-symbol table builders in the Huffman compressor. It takes a single stream of long-symbol histogram beats and steers each whole frame to one idle, enabled builder, alternating between builders round-robin. It stalls the stream when no builder is free. It records the frame seq_id per builder and exposes a 2-entry completion-order queue, so the downstream symbol-assembly stage reads builders in frame order. It sits between the long histogram writer and the two table-builder instances.

## Interface
- SEQ_W, 5, seq_id width
- CNT_W, 16, dispatch counter width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_val  in  1  histogram beat valid
- in_eob  in  1  last beat of frame (qualifies in_val)
- in_seq_id  in  SEQ_W  frame id, sampled on first beat
- in_stall  out  1  beat not accepted this cycle (combinational)
- bld_val  out  2  one-hot beat strobe to builder 0/1 (combinational)
- bld_not_ready  in  2  per-builder backpressure
- bld_read_done  in  2  per-builder pulse: table consumed, builder free
- sw_enable  in  2  builder enable mask, static or quasi-static
- bld0_seq_id, bld1_seq_id  out  SEQ_W  seq_id of frame owned by each builder
- sa_sel  out  1  builder index at head of order queue
- sa_sel_vld  out  1  order queue non-empty
- dispatch_cnt0, dispatch_cnt1  out  CNT_W  frames dispatched per builder, saturating
- order_err  out  1  one-cycle pulse on out-of-order or spurious done

## Operation
- Each builder has its own FSM with states IDLE, LOAD, BUSY.
- Frame start: the first accepted beat while no frame is open.
  - Eligible builder: IDLE and sw_enable bit set.
  - Pick rr_ptr if it is eligible, else the other builder if it is eligible. If neither is eligible, in_stall=1 and nothing changes.
  - On acceptance, sel is latched for the rest of the frame, rr_ptr <= ~sel, and bldN_seq_id <= in_seq_id.
  - The builder index is pushed to the order queue and dispatch_cntN increments, holding at all-ones.
- A beat is accepted when in_val && !in_stall.
  - While a frame is open, in_stall = bld_not_ready[sel].
  - At frame start, in_stall = (no eligible builder) || bld_not_ready[chosen].
  - bld_val[i] = accepted && (route==i), where route is the chosen builder at frame start and sel otherwise.
- FSM transitions:
  - IDLE->LOAD on an accepted non-eob first beat.
  - IDLE->BUSY on an accepted eob first beat (single-beat frame).
  - LOAD->BUSY on an accepted eob beat; this closes the frame.
  - BUSY->IDLE on bld_read_done[i] when i == sa_sel and sa_sel_vld; this also pops the queue.
- Error cases: bld_read_done[i] for a builder that is not BUSY, or that is not the queue head, pulses order_err for one cycle. It changes no state.
- If both done bits are high in the same cycle, only the head's bit is honoured and order_err pulses.
- Clearing an sw_enable bit only blocks new frames. An in-flight LOAD/BUSY on that builder completes normally.
- Order queue is 2 deep and cannot overflow (at most 2 non-IDLE builders). Push and pop in the same cycle are legal.

## Timing
- Reset values:
  - Both FSMs IDLE, rr_ptr=0, no frame open.
  - Order queue empty: sa_sel=0, sa_sel_vld=0.
  - bld0_seq_id = bld1_seq_id = 0, dispatch counters 0, order_err=0.
  - bld_val=0. in_stall = (sw_enable==0).
- Beat path has zero latency: in_val to bld_val and in_stall is combinational.
- State, seq_id, queue and counters update on the edge of acceptance.
- A builder freed by bld_read_done in cycle N is eligible for a new frame from cycle N+1, not in N.
- sa_sel/sa_sel_vld update the cycle after a push or pop.
- An async reset mid-frame clears everything. The open frame is dropped and the next beat is treated as a frame start.

## Test plan
- Back-to-back single-beat frames, seq 3 then 4, both enabled, no done:
  - Frame 3 goes to builder 0, frame 4 to builder 1.
  - The third frame stalls.
  - bld0_seq_id=3, bld1_seq_id=4, sa_sel=0, sa_sel_vld=1.
- 4-beat frame with bld_not_ready[0] asserted for 2 cycles mid-frame:
  - in_stall=1 for exactly those 2 cycles.
  - Four bld_val[0] pulses, state ends BUSY, dispatch_cnt0=1.
- sw_enable=2'b10 with three frames, releasing each via done:
  - All frames go to builder 1.
  - dispatch_cnt0=0, dispatch_cnt1=3.
- Both builders BUSY (head=0):
  - bld_read_done[1] first gives an order_err pulse and both builders stay BUSY.
  - Then done[0] frees builder 0; sa_sel becomes 1 one cycle later.
- done[0] in cycle N while a new frame is waiting and builder 1 is BUSY: the frame stalls in N and is accepted in N+1 into builder 0.
- Assert rst during beat 2 of a 5-beat frame:
  - All outputs return to reset values.
  - The next beat opens a new frame on builder 0.
